// File: rtl/maxpool_pkg.sv
// Shared types and sizing helpers for the maxpool2 pooling stage.
package maxpool_pkg;

  localparam int unsigned WIDTH_BIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Output edge length; trailing rows/cols that do not fill a window are dropped.
  function automatic int unsigned osize(input int unsigned size, input int unsigned pool);
    return size / pool;
  endfunction

  // Counter width for a range of values 0..range-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/pool_window_max.sv
// Running signed maximum over one pooling window.
// MAXPOOL_RELU_EN clamps negative samples to zero before they are compared.
module pool_window_max
  import maxpool_pkg::*;
#(
  parameter int unsigned WIDTH_BIT = WIDTH_BIT_DEF
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 load,
  input  logic                 update,
  input  logic [WIDTH_BIT-1:0] sample,
  output logic [WIDTH_BIT-1:0] max_val
);

  logic [WIDTH_BIT-1:0] sample_c;
  logic                 greater_c;

`ifdef MAXPOOL_RELU_EN
  assign sample_c = sample[WIDTH_BIT-1] ? '0 : sample;
`else
  assign sample_c = sample;
`endif

  // Strictly greater so that ties keep the value already held.
  assign greater_c = $signed(sample_c) > $signed(max_val);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      max_val <= '0;
    end else if (load) begin
      max_val <= sample_c;
    end else if (update && greater_c) begin
      max_val <= sample_c;
    end
  end

endmodule

// File: rtl/maxpool2.sv
// Non-overlapping POOLxPOOL max pooling of a SIZExSIZE matrix, one element per cycle.
// Optional ReLU fusion is selected with the MAXPOOL_RELU_EN macro (see pool_window_max).
module maxpool2
  import maxpool_pkg::*;
#(
  parameter int unsigned SIZE      = 98,
  parameter int unsigned POOL      = 2,
  parameter int unsigned WIDTH_BIT = WIDTH_BIT_DEF,
  localparam int unsigned OSIZE    = osize(SIZE, POOL)
) (
  input  logic                                        clock,
  input  logic                                        nreset,
  input  logic                                        start,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]    inpMatrix,
  output logic                                        busy,
  output logic                                        done,
  output logic [OSIZE-1:0][OSIZE-1:0][WIDTH_BIT-1:0]  poolOut
);

  localparam int unsigned PP = POOL * POOL;
  localparam int unsigned RW = cnt_w(OSIZE);
  localparam int unsigned KW = cnt_w(PP);
  localparam int unsigned AW = cnt_w(SIZE);

  state_t               state;
  state_t               state_next;
  logic [RW-1:0]        row;
  logic [RW-1:0]        col;
  logic [KW-1:0]        k;
  logic [AW-1:0]        row_idx;
  logic [AW-1:0]        col_idx;
  logic [WIDTH_BIT-1:0] max_val;
  logic                 k_last;
  logic                 row_last;
  logic                 col_last;
  logic                 clr_c;
  logic                 scan_c;
  logic                 load_c;
  logic                 update_c;
  logic                 write_c;

  assign k_last   = (k == KW'(PP - 1));
  assign row_last = (row == RW'(OSIZE - 1));
  assign col_last = (col == RW'(OSIZE - 1));

  // Element of the current window selected by the window index k.
  always_comb begin
    row_idx = AW'(32'(row) * POOL + 32'(k) / POOL);
    col_idx = AW'(32'(col) * POOL + 32'(k) % POOL);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clr_c      = 1'b0;
    scan_c     = 1'b0;
    load_c     = 1'b0;
    update_c   = 1'b0;
    write_c    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clr_c      = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        scan_c   = 1'b1;
        load_c   = (k == '0);
        update_c = (k != '0);
        if (k_last) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        write_c    = 1'b1;
        state_next = (row_last && col_last) ? DONE : SCAN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags follow the state being entered so they line up with it.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SCAN) || (state_next == WRITE);
      done <= (state_next == DONE);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row <= '0;
      col <= '0;
      k   <= '0;
    end else if (clr_c) begin
      row <= '0;
      col <= '0;
      k   <= '0;
    end else if (scan_c) begin
      if (!k_last) begin
        k <= k + KW'(1);
      end
    end else if (write_c) begin
      k <= '0;
      if (col_last) begin
        col <= '0;
        if (!row_last) begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + RW'(1);
      end
    end
  end

  pool_window_max #(
    .WIDTH_BIT (WIDTH_BIT)
  ) u_window (
    .clock   (clock),
    .nreset  (nreset),
    .load    (load_c),
    .update  (update_c),
    .sample  (inpMatrix[row_idx][col_idx]),
    .max_val (max_val)
  );

  // Each pooled element changes only on its own WRITE cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      poolOut <= '0;
    end else if (write_c) begin
      poolOut[row][col] <= max_val;
    end
  end

endmodule

// File: tb/tb_maxpool2.sv
// Randomized, self-checking bench for maxpool2 with a cycle-level reference model.
module tb_maxpool2;

  localparam int unsigned W   = 16;
  localparam int unsigned S4  = 4;
  localparam int unsigned S5  = 5;
  localparam int unsigned P   = 2;
  localparam int unsigned O   = 2;
  localparam int unsigned PP  = P * P;
  localparam int          LAT = O * O * (PP + 1);
`ifdef MAXPOOL_RELU_EN
  localparam logic [W-1:0] NEG_EXP = 16'h0000;
`else
  localparam logic [W-1:0] NEG_EXP = 16'hFFFF;
`endif

  logic clock = 1'b0;
  logic nreset;
  logic start4, start5;
  logic busy4, done4, busy5, done5;
  logic [S4-1:0][S4-1:0][W-1:0] inp4;
  logic [S5-1:0][S5-1:0][W-1:0] inp5;
  logic [O-1:0][O-1:0][W-1:0]   pool4, pool5;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  maxpool2 #(.SIZE(S4), .POOL(P), .WIDTH_BIT(W)) u4 (
    .clock(clock), .nreset(nreset), .start(start4), .inpMatrix(inp4),
    .busy(busy4), .done(done4), .poolOut(pool4)
  );

  maxpool2 #(.SIZE(S5), .POOL(P), .WIDTH_BIT(W)) u5 (
    .clock(clock), .nreset(nreset), .start(start5), .inpMatrix(inp5),
    .busy(busy5), .done(done5), .poolOut(pool5)
  );

  // Max of one window computed directly from the matrix.
  function automatic logic [W-1:0] ref_max4(input logic [S4-1:0][S4-1:0][W-1:0] m,
                                            input int r, input int c);
    int best, v;
    logic [W-1:0] e;
    best = 0;
    for (int dr = 0; dr < int'(P); dr++) begin
      for (int dc = 0; dc < int'(P); dc++) begin
        e = m[r*P+dr][c*P+dc];
        v = int'($signed(e));
`ifdef MAXPOOL_RELU_EN
        if (v < 0) v = 0;
`endif
        if ((dr == 0 && dc == 0) || v > best) best = v;
      end
    end
    return W'(best);
  endfunction

  // Timing model: pooled element j lands (j+1)*(PP+1) edges after the accepting edge.
  logic [O-1:0][O-1:0][W-1:0] m_pool = '0;
  logic [O-1:0][O-1:0][W-1:0] m_tgt  = '0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_n = 0;
  int   m_j = 0;

  initial forever begin
    @(posedge clock or negedge nreset);
    if (!nreset) begin
      m_pool = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_n    = 0;
    end else if (!m_busy) begin
      if (start4) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        m_n    = 0;
        for (int r = 0; r < int'(O); r++)
          for (int c = 0; c < int'(O); c++)
            m_tgt[r][c] = ref_max4(inp4, r, c);
      end
    end else begin
      m_n++;
      if (m_n % (PP + 1) == 0) begin
        m_j = m_n / (PP + 1) - 1;
        m_pool[m_j / O][m_j % O] = m_tgt[m_j / O][m_j % O];
      end
      if (m_n == LAT) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      total++;
      if ({busy4, done4, pool4} !== {m_busy, m_done, m_pool}) begin
        bad++;
        $display("FAIL cycle_check t=%0t got busy=%b done=%b pool=%h exp busy=%b done=%b pool=%h",
                 $time, busy4, done4, pool4, m_busy, m_done, m_pool);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  // One run; optional start re-pulse at cycle repulse, optional reset at cycle abort_at.
  task automatic run(input bit sel5, input int repulse, input int abort_at,
                     output int cyc, output int bcnt);
    tick();
    if (sel5) start5 = 1'b1; else start4 = 1'b1;
    @(posedge clock);
    #1;
    start4 = 1'b0;
    start5 = 1'b0;
    cyc  = 0;
    check("done_drops", 64'(sel5 ? done5 : done4), 64'd0);
    bcnt = int'(sel5 ? busy5 : busy4);
    while (!(sel5 ? done5 : done4) && cyc < 200) begin
      if (abort_at != 0 && cyc == abort_at) begin
        nreset = 1'b0;
        break;
      end
      if (!sel5) start4 = (repulse != 0 && cyc == repulse);
      @(posedge clock);
      #1;
      cyc++;
      bcnt += int'(sel5 ? busy5 : busy4);
    end
    start4 = 1'b0;
    if (cyc >= 200) begin
      total++;
      bad++;
      $display("FAIL run_timeout got=%0d cycles exp=%0d", cyc, LAT);
    end
  endtask

  task automatic check_all4(input string name);
    for (int r = 0; r < int'(O); r++)
      for (int c = 0; c < int'(O); c++)
        check(name, 64'(pool4[r][c]), 64'(ref_max4(inp4, r, c)));
  endtask

  int cyc, bcnt;

  initial begin
    nreset = 1'b1;
    start4 = 1'b0;
    start5 = 1'b0;
    inp4   = '0;
    inp5   = '0;
    #1 nreset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_busy", 64'(busy4), 64'd0);
    check("reset_done", 64'(done4), 64'd0);
    check("reset_pool", 64'(pool4), 64'd0);
    #1;
    nreset = 1'b1;
    chk_en = 1'b1;

    // Row-major ramp.
    for (int r = 0; r < int'(S4); r++)
      for (int c = 0; c < int'(S4); c++)
        inp4[r][c] = W'(r * S4 + c);
    run(1'b0, 0, 0, cyc, bcnt);
    check("ramp_latency", 64'(cyc), 64'(LAT));
    check("ramp_busy_cycles", 64'(bcnt), 64'(LAT));
    check("ramp_00", 64'(pool4[0][0]), 64'd5);
    check("ramp_01", 64'(pool4[0][1]), 64'd7);
    check("ramp_10", 64'(pool4[1][0]), 64'd13);
    check("ramp_11", 64'(pool4[1][1]), 64'd15);

    // Negative values, a single small positive in the first window.
    tick();
    inp4 = '1;
    inp4[1][1] = 16'h0003;
    run(1'b0, 0, 0, cyc, bcnt);
    check("signed_latency", 64'(cyc), 64'(LAT));
    check("signed_00", 64'(pool4[0][0]), 64'h3);
    check("signed_01", 64'(pool4[0][1]), 64'(NEG_EXP));
    check("signed_10", 64'(pool4[1][0]), 64'(NEG_EXP));
    check("signed_11", 64'(pool4[1][1]), 64'(NEG_EXP));

    // Start re-pulsed mid-run must be ignored.
    tick();
    for (int r = 0; r < int'(S4); r++)
      for (int c = 0; c < int'(S4); c++)
        inp4[r][c] = W'($urandom);
    run(1'b0, 7, 0, cyc, bcnt);
    check("repulse_latency", 64'(cyc), 64'(LAT));
    check_all4("repulse_pool");

    // Reset in the middle of a run.
    tick();
    for (int r = 0; r < int'(S4); r++)
      for (int c = 0; c < int'(S4); c++)
        inp4[r][c] = W'($urandom);
    run(1'b0, 0, 10, cyc, bcnt);
    #1;
    check("abort_busy", 64'(busy4), 64'd0);
    check("abort_done", 64'(done4), 64'd0);
    check("abort_pool", 64'(pool4), 64'd0);
    tick();
    nreset = 1'b1;
    run(1'b0, 0, 0, cyc, bcnt);
    check("after_abort_latency", 64'(cyc), 64'(LAT));
    check_all4("after_abort_pool");

    // Back-to-back random runs started while done is high.
    for (int n = 0; n < 4; n++) begin
      tick();
      for (int r = 0; r < int'(S4); r++)
        for (int c = 0; c < int'(S4); c++)
          inp4[r][c] = W'($urandom);
      run(1'b0, 0, 0, cyc, bcnt);
      check("rand_latency", 64'(cyc), 64'(LAT));
      check_all4("rand_pool");
    end

    // Odd size: trailing row/col hold large values that must never be read.
    tick();
    for (int r = 0; r < int'(S5); r++)
      for (int c = 0; c < int'(S5); c++)
        inp5[r][c] = (r == 4 || c == 4) ? 16'h7FFF : 16'h0001;
    run(1'b1, 0, 0, cyc, bcnt);
    check("odd_latency", 64'(cyc), 64'(LAT));
    for (int r = 0; r < int'(O); r++)
      for (int c = 0; c < int'(O); c++)
        check("odd_pool", 64'(pool5[r][c]), 64'd1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
